gb_timer: RTL and testbench

- Game Boy DIV/TIMA/TMA/TAC timer block, memory-mapped at FF04-FF07.
- Directly upstream of the interrupt controller: drives I_TIMER_INTERRUPT with a one-cycle pulse on TIMA overflow.
- Decodes CPU writes on the shared CPU address/data bus and supplies read data for the four registers.
- Runs on the system clock; the system clock is the 4.194304 MHz T-cycle clock.

---
 rtl/gb_timer.sv | 151 +++++++++++++++
 tb/tb_gb_timer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/gb_timer.sv
// Game Boy DIV/TIMA/TMA/TAC timer at FF04-FF07 with delayed TMA reload and overflow interrupt.
// Optional GB_TIMER_EDGE_GLITCH_EN: CPU writes to DIV/TAC may produce a spurious falling-edge tick.
module gb_timer #(
    parameter int unsigned RELOAD_DELAY = 4
) (
    input  logic        I_CLOCK,
    input  logic        I_RESET,
    input  logic [15:0] I_CPU_ADDR,
    input  logic [7:0]  I_CPU_DATA,
    input  logic        I_MEM_WE_L,
    output logic [7:0]  O_DATA,
    output logic        O_DATA_VALID,
    output logic        O_TIMER_INTERRUPT,
    output logic [7:0]  O_DIV
);

    localparam int unsigned DIV_W   = 16;
    localparam int unsigned DELAY_W = 4;

    typedef enum logic {
        COUNT    = 1'b0,
        OVF_WAIT = 1'b1
    } state_t;

    state_t             state, state_next;
    logic [DIV_W-1:0]   div_cnt, div_next;
    logic [7:0]         tima, tima_next;
    logic [7:0]         tma, tma_next;
    logic [2:0]         tac, tac_next;
    logic               edge_prev, edge_next;
    logic [DELAY_W-1:0] delay, delay_next;
    logic               irq, irq_next;

    logic wr, wr_div, wr_tima, wr_tma, wr_tac;
    logic sig, sig_post, tick;

    // Enable-gated tap bit selected by TAC[1:0]
    function automatic logic tap_sig(input logic [DIV_W-1:0] d, input logic [2:0] t);
        logic b;
        case (t[1:0])
            2'b00:   b = d[9];
            2'b01:   b = d[3];
            2'b10:   b = d[5];
            default: b = d[7];
        endcase
        return t[2] & b;
    endfunction

    assign wr      = ~I_MEM_WE_L;
    assign wr_div  = wr && (I_CPU_ADDR == 16'hFF04);
    assign wr_tima = wr && (I_CPU_ADDR == 16'hFF05);
    assign wr_tma  = wr && (I_CPU_ADDR == 16'hFF06);
    assign wr_tac  = wr && (I_CPU_ADDR == 16'hFF07);

    assign div_next = wr_div ? '0 : div_cnt + DIV_W'(1);
    assign tac_next = wr_tac ? I_CPU_DATA[2:0] : tac;
    assign tma_next = wr_tma ? I_CPU_DATA : tma;

    assign sig      = tap_sig(div_cnt, tac);
    assign sig_post = tap_sig(div_next, tac_next);
    assign tick     = edge_prev & ~sig;

    // Edge detector history; only the default build re-syncs it across CPU writes
    always_comb begin
        edge_next = sig;
`ifdef GB_TIMER_EDGE_GLITCH_EN
        edge_next = sig;
`else
        if (wr_div || wr_tac) begin
            edge_next = sig_post;
        end
`endif
    end

    // Next-state and TIMA/reload control
    always_comb begin
        state_next = state;
        tima_next  = tima;
        delay_next = delay;
        irq_next   = 1'b0;
        case (state)
            COUNT: begin
                if (wr_tima) begin
                    tima_next = I_CPU_DATA;
                end else if (tick) begin
                    if (tima == 8'hFF) begin
                        tima_next  = 8'h00;
                        delay_next = DELAY_W'(RELOAD_DELAY - 1);
                        state_next = OVF_WAIT;
                    end else begin
                        tima_next = tima + 8'd1;
                    end
                end
            end
            OVF_WAIT: begin
                if (delay == '0) begin
                    // Reload cycle: TMA (including a same-cycle TMA write) beats a TIMA write
                    tima_next  = tma_next;
                    irq_next   = 1'b1;
                    state_next = COUNT;
                end else if (wr_tima) begin
                    tima_next  = I_CPU_DATA;
                    delay_next = '0;
                    state_next = COUNT;
                end else begin
                    delay_next = delay - DELAY_W'(1);
                end
            end
            default: state_next = COUNT;
        endcase
    end

    always_ff @(posedge I_CLOCK or negedge I_RESET) begin
        if (!I_RESET) begin
            state     <= COUNT;
            div_cnt   <= '0;
            tima      <= '0;
            tma       <= '0;
            tac       <= '0;
            edge_prev <= 1'b0;
            delay     <= '0;
            irq       <= 1'b0;
        end else begin
            state     <= state_next;
            div_cnt   <= div_next;
            tima      <= tima_next;
            tma       <= tma_next;
            tac       <= tac_next;
            edge_prev <= edge_next;
            delay     <= delay_next;
            irq       <= irq_next;
        end
    end

    // Combinational register read port
    always_comb begin
        O_DATA       = 8'h00;
        O_DATA_VALID = 1'b0;
        case (I_CPU_ADDR)
            16'hFF04: begin O_DATA = div_cnt[15:8];       O_DATA_VALID = 1'b1; end
            16'hFF05: begin O_DATA = tima;                O_DATA_VALID = 1'b1; end
            16'hFF06: begin O_DATA = tma;                 O_DATA_VALID = 1'b1; end
            16'hFF07: begin O_DATA = {5'b11111, tac};     O_DATA_VALID = 1'b1; end
            default:  begin O_DATA = 8'h00;               O_DATA_VALID = 1'b0; end
        endcase
    end

    assign O_TIMER_INTERRUPT = irq;
    assign O_DIV             = div_cnt[15:8];

endmodule

// File: tb/tb_gb_timer.sv
// Self-checking bench for gb_timer: table-driven register/counter vectors plus overflow corner sequences.
module tb_gb_timer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic [7:0]  wdata = 8'h00;
    logic        we_l = 1'b1;
    logic [7:0]  rdata;
    logic        rvalid;
    logic        irq;
    logic [7:0]  div;

    int checks = 0;
    int errors = 0;

    gb_timer #(.RELOAD_DELAY(4)) dut (
        .I_CLOCK           (clk),
        .I_RESET           (rst_n),
        .I_CPU_ADDR        (addr),
        .I_CPU_DATA        (wdata),
        .I_MEM_WE_L        (we_l),
        .O_DATA            (rdata),
        .O_DATA_VALID      (rvalid),
        .O_TIMER_INTERRUPT (irq),
        .O_DIV             (div)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [7:0]  data;
        int          n;
        logic [15:0] raddr;
        logic [7:0]  exp_data;
        logic        exp_valid;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        addr  = a;
        wdata = d;
        we_l  = 1'b0;
        step(1);
        we_l  = 1'b1;
    endtask

    task automatic rd(input string name, input logic [15:0] a, input logic [7:0] exp);
        addr = a;
        #1;
        chk(name, {8'h00, rdata}, {8'h00, exp});
    endtask

    task automatic do_reset();
        we_l  = 1'b1;
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    // Reset, enable fast tap, zero DIV (E0), TMA=AB (E1), TIMA=value (E2)
    task automatic setup_ovf(input logic [7:0] tima_val);
        do_reset();
        wr(16'hFF07, 8'h05);
        wr(16'hFF04, 8'h00);
        wr(16'hFF06, 8'hAB);
        wr(16'hFF05, tima_val);
    endtask

    initial begin
        logic seen;

        vecs[0]  = '{16'hFF07, 1'b1, 8'h05,   1, 16'hFF07, 8'hFD, 1'b1, 1'b0};
        vecs[1]  = '{16'hFF04, 1'b1, 8'h9C,   1, 16'hFF04, 8'h00, 1'b1, 1'b0};
        vecs[2]  = '{16'hFF05, 1'b0, 8'h33,  16, 16'hFF05, 8'h00, 1'b1, 1'b0};
        vecs[3]  = '{16'hFF05, 1'b0, 8'h33,   1, 16'hFF05, 8'h01, 1'b1, 1'b0};
        vecs[4]  = '{16'hFF05, 1'b0, 8'h33, 143, 16'hFF05, 8'h09, 1'b1, 1'b0};
        vecs[5]  = '{16'hFF05, 1'b0, 8'h33,   1, 16'hFF05, 8'h0A, 1'b1, 1'b0};
        vecs[6]  = '{16'hFF04, 1'b0, 8'h33,  94, 16'hFF04, 8'h00, 1'b1, 1'b0};
        vecs[7]  = '{16'hFF04, 1'b0, 8'h33,   1, 16'hFF04, 8'h01, 1'b1, 1'b0};
        vecs[8]  = '{16'hFF08, 1'b0, 8'h00,   0, 16'hFF08, 8'h00, 1'b0, 1'b0};
        vecs[9]  = '{16'hFF03, 1'b0, 8'h00,   0, 16'hFF03, 8'h00, 1'b0, 1'b0};
        vecs[10] = '{16'hFF06, 1'b1, 8'h5A,   1, 16'hFF06, 8'h5A, 1'b1, 1'b0};
        vecs[11] = '{16'hFF08, 1'b1, 8'h77,   1, 16'hFF06, 8'h5A, 1'b1, 1'b0};

        // Values while reset is held
        #2;
        rd("rst_div", 16'hFF04, 8'h00);
        rd("rst_tima", 16'hFF05, 8'h00);
        rd("rst_tac", 16'hFF07, 8'hF8);
        chk("rst_valid", {15'h0, rvalid}, 16'h0001);
        chk("rst_odiv", {8'h00, div}, 16'h0000);
        chk("rst_irq", {15'h0, irq}, 16'h0000);

        do_reset();
        foreach (vecs[i]) begin
            addr  = vecs[i].addr;
            wdata = vecs[i].data;
            if (vecs[i].n > 0) begin
                we_l = ~vecs[i].we;
                step(1);
                we_l = 1'b1;
                if (vecs[i].n > 1) step(vecs[i].n - 1);
            end
            addr = vecs[i].raddr;
            #1;
            chk($sformatf("vec%0d_data", i), {8'h00, rdata}, {8'h00, vecs[i].exp_data});
            chk($sformatf("vec%0d_valid", i), {15'h0, rvalid}, {15'h0, vecs[i].exp_valid});
            chk($sformatf("vec%0d_irq", i), {15'h0, irq}, {15'h0, vecs[i].exp_irq});
        end

        // Overflow with delayed reload
        setup_ovf(8'hFF);
        step(14);
        rd("ovf_pre", 16'hFF05, 8'hFF);
        for (int k = 0; k < 4; k++) begin
            step(1);
            rd($sformatf("ovf_zero%0d", k), 16'hFF05, 8'h00);
            chk($sformatf("ovf_noirq%0d", k), {15'h0, irq}, 16'h0000);
        end
        step(1);
        rd("ovf_reload", 16'hFF05, 8'hAB);
        chk("ovf_irq", {15'h0, irq}, 16'h0001);
        step(1);
        chk("ovf_irq_end", {15'h0, irq}, 16'h0000);

        // TIMA write two cycles into the wait cancels reload and interrupt
        setup_ovf(8'hFF);
        step(16);
        wr(16'hFF05, 8'h42);
        rd("cancel_tima", 16'hFF05, 8'h42);
        seen = 1'b0;
        for (int k = 0; k < 13; k++) begin
            step(1);
            if (irq) seen = 1'b1;
        end
        chk("cancel_noirq", {15'h0, seen}, 16'h0000);
        rd("cancel_hold", 16'hFF05, 8'h42);
        step(1);
        rd("cancel_resume", 16'hFF05, 8'h43);

        // TMA write in the reload cycle passes straight into TIMA
        setup_ovf(8'hFF);
        step(18);
        wr(16'hFF06, 8'h77);
        rd("tma_wt_tima", 16'hFF05, 8'h77);
        chk("tma_wt_irq", {15'h0, irq}, 16'h0001);
        rd("tma_wt_tma", 16'hFF06, 8'h77);

        // TIMA write in the reload cycle loses to TMA
        setup_ovf(8'hFF);
        step(18);
        wr(16'hFF05, 8'h55);
        rd("tima_rl_tima", 16'hFF05, 8'hAB);
        chk("tima_rl_irq", {15'h0, irq}, 16'h0001);

        // TIMA write coinciding with a tick: written value wins
        do_reset();
        wr(16'hFF07, 8'h05);
        wr(16'hFF04, 8'h00);
        wr(16'hFF05, 8'h10);
        step(15);
        wr(16'hFF05, 8'h20);
        rd("coll_tima", 16'hFF05, 8'h20);
        step(15);
        rd("coll_hold", 16'hFF05, 8'h20);
        step(1);
        rd("coll_next", 16'hFF05, 8'h21);

        // DIV reset while the selected tap is high
        do_reset();
        wr(16'hFF07, 8'h05);
        wr(16'hFF04, 8'h00);
        wr(16'hFF05, 8'h05);
        step(7);
        wr(16'hFF04, 8'h00);
        rd("glitch_pre", 16'hFF05, 8'h05);
        step(1);
`ifdef GB_TIMER_EDGE_GLITCH_EN
        rd("glitch_tima", 16'hFF05, 8'h06);
`else
        rd("glitch_tima", 16'hFF05, 8'h05);
`endif

        // Reset asserted during the reload wait
        setup_ovf(8'hFF);
        step(16);
        #2;
        rst_n = 1'b0;
        #1;
        rd("mid_rst_tima", 16'hFF05, 8'h00);
        rd("mid_rst_tma", 16'hFF06, 8'h00);
        rd("mid_rst_tac", 16'hFF07, 8'hF8);
        chk("mid_rst_div", {8'h00, div}, 16'h0000);
        chk("mid_rst_irq", {15'h0, irq}, 16'h0000);
        step(2);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step(1);
            if (irq) seen = 1'b1;
        end
        chk("post_rst_noirq", {15'h0, seen}, 16'h0000);
        rd("post_rst_tima", 16'hFF05, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
